card_shoe: RTL

Shuffled card source for the baccarat datapath: holds a shoe of NUM_DECKS standard decks, shuffles it in place with an LFSR-driven Fisher-Yates pass, then deals one card per request. Card values use the 4-bit rank encoding the hand scorer consumes: 1=A, 2..10 face value, 11=J, 12=Q, 13=K. A value above 9 scores zero downstream. Sits between the game state machine (request side) and the player/banker card registers.

---
 rtl/card_shoe_if.sv | 38 +++
 rtl/card_shoe.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/card_shoe_if.sv
// card_shoe_if: request/deal bundle between the game state machine and the card shoe.
//   shuffle_start : one-cycle pulse, refill and reshuffle the shoe
//   deal_req      : request one card (sampled every cycle)
//   ready         : shoe shuffled and accepting deal_req
//   card_valid    : card carries a dealt card this cycle
//   card          : dealt rank 1..13
//   cards_left    : undealt cards remaining
//   shoe_empty    : cards_left == 0
// master = game side (requester), slave = shoe side.
interface card_shoe_if;
    logic       shuffle_start;
    logic       deal_req;
    logic       ready;
    logic       card_valid;
    logic [3:0] card;
    logic [7:0] cards_left;
    logic       shoe_empty;

    modport master (
        output shuffle_start,
        output deal_req,
        input  ready,
        input  card_valid,
        input  card,
        input  cards_left,
        input  shoe_empty
    );

    modport slave (
        input  shuffle_start,
        input  deal_req,
        output ready,
        output card_valid,
        output card,
        output cards_left,
        output shoe_empty
    );
endinterface

// File: rtl/card_shoe.sv
// card_shoe: shuffled card source. Fills a shoe of NUM_DECKS decks, shuffles it in place with an
// LFSR-driven Fisher-Yates pass (rejection-sampled index), then deals one card per request.
// Ports:
//   clock  : sole clock, rising edge
//   resetb : asynchronous active-low reset
//   bus    : card_shoe_if.slave (shuffle_start, deal_req in; ready, card_valid, card,
//            cards_left, shoe_empty out)
module card_shoe #(
    parameter int unsigned NUM_DECKS = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clock,
    input  logic       resetb,
    card_shoe_if.slave bus
);
    localparam int N    = 52 * NUM_DECKS;
    localparam int IdxW = $clog2(N);

    localparam logic [IdxW-1:0] LastIdx   = IdxW'(N - 1);
    localparam logic [IdxW-1:0] OneIdx    = IdxW'(1);
    localparam logic [7:0]      FullCount = 8'(N);

    typedef enum logic [1:0] {StIdle, StInit, StShuffle, StReady} state_e;

    state_e          state_q, state_d;
    logic [3:0]      deck_q [N];
    logic [IdxW-1:0] j_q;          // fill index in INIT, swap index in SHUFFLE
    logic [IdxW-1:0] ptr_q;
    logic [3:0]      rank_q;       // (j mod 13)+1 tracked incrementally during INIT
    logic [3:0]      card_q;
    logic            card_valid_q;
    logic [7:0]      cards_left_q;
    logic [15:0]     lfsr_q;

    logic            start_en, init_en, swap_en, deal_en;
    logic [IdxW-1:0] mask, r;
    logic            fb;

    // x^16 + x^14 + x^13 + x^11 + 1
    assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Smearing j right gives 2^ceil(log2(j+1)) - 1, the smallest all-ones mask covering j.
    always_comb begin
        mask = j_q;
        for (int k = 1; k < IdxW; k++) begin
            mask = mask | (j_q >> k);
        end
        r = lfsr_q[IdxW-1:0] & mask;
    end

    always_comb begin
        state_d  = state_q;
        start_en = 1'b0;
        init_en  = 1'b0;
        swap_en  = 1'b0;
        deal_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.shuffle_start) begin
                    start_en = 1'b1;
                    state_d  = StInit;
                end
            end
            StInit: begin
                init_en = 1'b1;
                if (j_q == LastIdx) begin
                    state_d = StShuffle;
                end
            end
            StShuffle: begin
                // Out-of-range candidates are rejected; the LFSR has moved on by next cycle.
                if (r <= j_q) begin
                    swap_en = 1'b1;
                    if (j_q == OneIdx) begin
                        state_d = StReady;
                    end
                end
            end
            StReady: begin
                // A reshuffle request takes priority over a simultaneous deal.
                if (bus.shuffle_start) begin
                    start_en = 1'b1;
                    state_d  = StInit;
                end else if (bus.deal_req && (cards_left_q != 8'd0)) begin
                    deal_en = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= StIdle;
            lfsr_q       <= LFSR_SEED;
            j_q          <= '0;
            ptr_q        <= '0;
            rank_q       <= 4'd1;
            card_q       <= 4'd0;
            card_valid_q <= 1'b0;
            cards_left_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= {lfsr_q[14:0], fb};
            card_valid_q <= deal_en;
            if (start_en) begin
                j_q          <= '0;
                rank_q       <= 4'd1;
                ptr_q        <= '0;
                cards_left_q <= 8'd0;
            end
            if (init_en) begin
                rank_q <= (rank_q == 4'd13) ? 4'd1 : rank_q + 4'd1;
                // Parking j at N-1 leaves it ready as the first swap index.
                if (j_q != LastIdx) begin
                    j_q <= j_q + OneIdx;
                end
            end
            if (swap_en) begin
                j_q <= j_q - OneIdx;
                if (j_q == OneIdx) begin
                    ptr_q        <= '0;
                    cards_left_q <= FullCount;
                end
            end
            if (deal_en) begin
                card_q       <= deck_q[ptr_q];
                ptr_q        <= ptr_q + OneIdx;
                cards_left_q <= cards_left_q - 8'd1;
            end
        end
    end

    // Deck contents need no reset; INIT rewrites every slot before use.
    always_ff @(posedge clock) begin
        if (init_en) begin
            deck_q[j_q] <= rank_q;
        end
        if (swap_en) begin
            deck_q[r]   <= deck_q[j_q];
            deck_q[j_q] <= deck_q[r];
        end
    end

    assign bus.ready      = (state_q == StReady);
    assign bus.card_valid = card_valid_q;
    assign bus.card       = card_q;
    assign bus.cards_left = cards_left_q;
    assign bus.shoe_empty = (cards_left_q == 8'd0);
endmodule
